// File: rtl/pe_8x4_16bit.sv
// Fixed-point processing element: N_OUT dot products of N_IN signed lanes.
// Stage 1 registers every full-precision product. Stage 2 sums each output's
// products, floors by 2^FRAC, saturates to WIDTH bits and registers into Q.
module pe_8x4_16bit #(
  parameter int WIDTH = 16,
  parameter int N_IN  = 8,
  parameter int N_OUT = 4,
  parameter int FRAC  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ce,
  input  logic [WIDTH*N_IN-1:0]          DATA,
  input  logic [WIDTH*N_IN*N_OUT-1:0]    WEIGHT,
  output logic [WIDTH*N_OUT-1:0]         Q
);

  localparam int PW    = 2 * WIDTH;
  localparam int GW    = $clog2(N_IN);
  localparam int SW    = PW + GW;
  localparam int NPROD = N_IN * N_OUT;

  // Saturation bounds expressed at the accumulator width.
  localparam logic signed [SW-1:0] SMAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]     QMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]     QMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [PW-1:0]    prod_d [NPROD];
  logic signed [PW-1:0]    prod_q [NPROD];
  logic [WIDTH*N_OUT-1:0]  q_d;
  logic [WIDTH*N_OUT-1:0]  q_q;

  // Stage 1 next state: full-precision signed product for every (output, input) pair.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        logic signed [PW-1:0] a_ext;
        logic signed [PW-1:0] b_ext;
        a_ext = PW'($signed(DATA[i*WIDTH +: WIDTH]));
        b_ext = PW'($signed(WEIGHT[(j*N_IN+i)*WIDTH +: WIDTH]));
        prod_d[j*N_IN+i] = a_ext * b_ext;
      end
    end
  end

  // Stage 2 next state: exact sum, arithmetic shift (floor), then saturate.
  always_comb begin
    q_d = '0;
    for (int j = 0; j < N_OUT; j++) begin
      logic signed [SW-1:0] acc;
      logic signed [SW-1:0] shf;
      logic [WIDTH-1:0]     lane;
      acc = '0;
      for (int i = 0; i < N_IN; i++) begin
        acc = acc + SW'(prod_q[j*N_IN+i]);
      end
      shf = acc >>> FRAC;
      if (shf > SMAX) begin
        lane = QMAX;
      end else if (shf < SMIN) begin
        lane = QMIN;
      end else begin
        lane = shf[WIDTH-1:0];
      end
      q_d[j*WIDTH +: WIDTH] = lane;
    end
  end

  // Both pipeline stages advance together on enabled edges; reset clears all in-flight data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NPROD; k++) begin
        prod_q[k] <= '0;
      end
      q_q <= '0;
    end else if (ce) begin
      for (int k = 0; k < NPROD; k++) begin
        prod_q[k] <= prod_d[k];
      end
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_pe_8x4_16bit.sv
// Directed and random bench for pe_8x4_16bit with a scoreboard queue of expected Q words.
module tb_pe_8x4_16bit;

  localparam int WIDTH = 16;
  localparam int N_IN  = 8;
  localparam int N_OUT = 4;
  localparam int FRAC  = 8;
  localparam int QW    = WIDTH * N_OUT;

  logic                        clk;
  logic                        rst_n;
  logic                        ce;
  logic [WIDTH*N_IN-1:0]       DATA;
  logic [WIDTH*N_IN*N_OUT-1:0] WEIGHT;
  logic [QW-1:0]               Q;

  logic [WIDTH-1:0] d [N_IN];
  logic [WIDTH-1:0] w [N_IN*N_OUT];

  logic [QW-1:0] sbq [$];
  int checks;
  int failures;

  pe_8x4_16bit #(
    .WIDTH(WIDTH),
    .N_IN (N_IN),
    .N_OUT(N_OUT),
    .FRAC (FRAC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .DATA  (DATA),
    .WEIGHT(WEIGHT),
    .Q     (Q)
  );

  // Pack lane arrays onto the flat buses.
  always_comb begin
    DATA   = '0;
    WEIGHT = '0;
    for (int i = 0; i < N_IN; i++) DATA[i*WIDTH +: WIDTH] = d[i];
    for (int k = 0; k < N_IN*N_OUT; k++) WEIGHT[k*WIDTH +: WIDTH] = w[k];
  end

  function automatic logic [QW-1:0] model();
    logic [QW-1:0] res;
    res = '0;
    for (int j = 0; j < N_OUT; j++) begin
      longint acc;
      acc = 0;
      for (int i = 0; i < N_IN; i++) begin
        acc += longint'($signed(d[i])) * longint'($signed(w[j*N_IN+i]));
      end
      acc = acc >>> FRAC;
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
      res[j*WIDTH +: WIDTH] = acc[WIDTH-1:0];
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [QW-1:0] got, input logic [QW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock period; enabled edges push the current expectation and check the one
  // that has made it through both stages.
  task automatic tick(input string tag);
    logic [QW-1:0] exp;
    if (ce) sbq.push_back(model());
    #5 clk = 1'b1;
    #1;
    if (ce && sbq.size() >= 2) begin
      exp = sbq.pop_front();
      check(tag, Q, exp);
    end
    #4 clk = 1'b0;
  endtask

  task automatic set_all(input logic [WIDTH-1:0] dv, input logic [WIDTH-1:0] wv);
    for (int i = 0; i < N_IN; i++) d[i] = dv;
    for (int k = 0; k < N_IN*N_OUT; k++) w[k] = wv;
  endtask

  task automatic set_rand();
    for (int i = 0; i < N_IN; i++) d[i] = WIDTH'($urandom());
    for (int k = 0; k < N_IN*N_OUT; k++) w[k] = WIDTH'($urandom());
  endtask

  // After reset the products are zero, so the first enabled edge puts 0 on Q.
  task automatic sb_reset();
    sbq.delete();
    sbq.push_back('0);
  endtask

  initial begin
    logic [QW-1:0] held;
    checks   = 0;
    failures = 0;
    clk   = 1'b0;
    ce    = 1'b1;
    rst_n = 1'b1;
    set_rand();

    // Reset with clock stopped must clear Q with no edge.
    #3 rst_n = 1'b0;
    #2;
    check("reset_no_clk", Q, '0);
    #5 rst_n = 1'b1;
    sb_reset();

    // Unit: 1.0 * 0.5 * 8 lanes = 4.0
    set_all(16'h0100, 16'h0080);
    tick("unit_e1");
    tick("unit_e2");
    check("unit_const", Q, {N_OUT{16'h0400}});

    set_all(16'h0B2A, 16'h2F04);
    tick("possat_e1");
    tick("possat_e2");
    check("possat_const", Q, {N_OUT{16'h7FFF}});

    set_all(16'h0B2A, 16'hD0FC);
    tick("negsat_e1");
    tick("negsat_e2");
    check("negsat_const", Q, {N_OUT{16'h8000}});

    // Lane indexing: identity weights select input lane j for output j.
    set_all(16'h0000, 16'h0000);
    for (int i = 0; i < N_IN; i++) d[i] = WIDTH'((i + 1) << 8);
    for (int j = 0; j < N_OUT; j++) w[j*N_IN+j] = 16'h0100;
    tick("lane_e1");
    tick("lane_e2");
    check("lane_const", Q, {16'h0400, 16'h0300, 16'h0200, 16'h0100});

    // Floor: -1 * 1 / 256 floors to -1 LSB.
    set_all(16'h0000, 16'h0000);
    d[0] = 16'hFFFF;
    for (int j = 0; j < N_OUT; j++) w[j*N_IN] = 16'h0001;
    tick("floor_e1");
    tick("floor_e2");
    check("floor_const", Q, {N_OUT{16'hFFFF}});

    // Enable hold: Q and stage-1 products freeze while ce is low.
    held = {N_OUT{16'hFFFF}};
    ce = 1'b0;
    for (int n = 0; n < 5; n++) begin
      set_rand();
      tick("hold_tick");
      check("hold_q", Q, held);
    end
    ce = 1'b1;
    set_all(16'h0100, 16'h0080);
    tick("resume_e1");
    tick("resume_e2");
    check("resume_const", Q, {N_OUT{16'h0400}});

    // Back-to-back random traffic, one result per enabled edge.
    for (int n = 0; n < 20; n++) begin
      set_rand();
      tick("stream");
    end

    // Mid-operation reset with clock stopped discards in-flight data.
    set_rand();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_q", Q, '0);
    #2 rst_n = 1'b1;
    sb_reset();
    set_rand();
    tick("post_reset_e1");
    tick("post_reset_e2");
    for (int n = 0; n < 6; n++) begin
      set_rand();
      tick("post_reset_stream");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
